tx_serial_xmit: RTL

//  Transmit half of the APB serial port: an 8-bit holding buffer plus an

---
 rtl/tx_serial_xmit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tx_serial_xmit.sv
`default_nettype none
// ============================================================================
//  Module   : tx_serial_xmit
//  Brief    : APB serial-port transmitter: one-byte holding buffer feeding an
//             async shifter (1 start, 8 data LSB-first, optional parity, 1 stop).
//             Define TX_PARITY_EN to insert an even-parity bit before STOP.
//  Revision : 1.0  initial release
// ============================================================================
module tx_serial_xmit #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_buffer,
    input  logic [7:0] tx_data,
    input  logic       error_clear,
    output logic       serial_out,
    output logic       buffer_empty,
    output logic       tx_active,
    output logic       tx_done,
    output logic       write_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       hold_q,    hold_d;
    logic             empty_q,   empty_d;
    logic             serial_q,  serial_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;
    logic             werr_q,    werr_d;

    logic w_transfer;
    logic w_bit_end;

    assign w_bit_end = (bit_cnt_q == c_LAST_CNT);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        w_transfer = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (!empty_q) begin
                    w_transfer = 1'b1;
                    state_d    = c_ST_START;
                    bit_cnt_d  = '0;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    state_d   = c_ST_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = c_ST_PARITY;
`else
                        state_d = c_ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) begin
                    state_d   = c_ST_STOP;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_end) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next frame so queued bytes leave no idle gap.
                    if (!empty_q) begin
                        w_transfer = 1'b1;
                        state_d    = c_ST_START;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = c_ST_IDLE;
                bit_cnt_d = '0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        shift_d = w_transfer ? hold_q : shift_q;
        hold_d  = hold_q;
        empty_d = empty_q;
        werr_d  = werr_q;

        // A write into a full buffer is accepted only if the shifter drains it this cycle.
        if (load_buffer && (empty_q || w_transfer)) begin
            hold_d  = tx_data;
            empty_d = 1'b0;
        end else if (w_transfer) begin
            empty_d = 1'b1;
        end

        if (load_buffer && !empty_q && !w_transfer) begin
            werr_d = 1'b1;
        end else if (error_clear) begin
            werr_d = 1'b0;
        end
    end

    always_comb begin
        case (state_d)
            c_ST_START:  serial_d = 1'b0;
            c_ST_DATA:   serial_d = shift_d[bit_idx_d];
`ifdef TX_PARITY_EN
            c_ST_PARITY: serial_d = ^shift_d;
`endif
            default:     serial_d = 1'b1;
        endcase
        active_d = (state_d != c_ST_IDLE);
        done_d   = (state_d == c_ST_STOP) && (bit_cnt_d == c_LAST_CNT);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= c_ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            hold_q    <= 8'hFF;
            empty_q   <= 1'b1;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            empty_q   <= empty_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
            werr_q    <= werr_d;
        end
    end

    assign serial_out   = serial_q;
    assign buffer_empty = empty_q;
    assign tx_active    = active_q;
    assign tx_done      = done_q;
    assign write_error  = werr_q;

endmodule
`default_nettype wire
